// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Hits complete combinationally;
// misses stall the CPU while the FSM writes back a dirty victim and refills a 4-word block.
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   memReadEn,
    input  logic [2:0]   memWriteEn,
    input  logic [31:0]  DATA_CACHE_ADDR,
    input  logic [31:0]  DATA_CACHE_DATA,
    output logic [31:0]  DATA_CACHE_READ_DATA,
    output logic         DATA_CACHE_BUSY_WAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDR,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t              state, next_state;
    logic [127:0]        data_array [LINES];
    logic [TAG_BITS-1:0] tag_array  [LINES];
    logic [LINES-1:0]    valid, dirty;
    logic [27:0]         miss_blk;
    logic [127:0]        refill_buf;

    logic [TAG_BITS-1:0]   tag, miss_tag;
    logic [INDEX_BITS-1:0] index, miss_index;
    logic                  is_store, is_load, access, hit, miss_start, store_hit;
    logic [127:0]          cur_line, merged_line;
    logic [31:0]           cur_word, merged_word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;

    assign tag        = DATA_CACHE_ADDR[31:4+INDEX_BITS];
    assign index      = DATA_CACHE_ADDR[4+INDEX_BITS-1:4];
    assign miss_tag   = miss_blk[27:INDEX_BITS];
    assign miss_index = miss_blk[INDEX_BITS-1:0];

    // A store wins when both enables are raised.
    assign is_store   = memWriteEn[2];
    assign is_load    = memReadEn[3] & ~is_store;
    assign access     = is_load | is_store;
    assign hit        = valid[index] && (tag_array[index] == tag);
    assign miss_start = (state == IDLE) && access && !hit;
    assign store_hit  = (state == IDLE) && is_store && hit;

    assign cur_line = data_array[index];
    assign cur_word = cur_line[{DATA_CACHE_ADDR[3:2], 5'b0} +: 32];
    assign sel_byte = cur_word[{DATA_CACHE_ADDR[1:0], 3'b0} +: 8];
    assign sel_half = cur_word[{DATA_CACHE_ADDR[1], 4'b0} +: 16];

    assign DATA_CACHE_BUSY_WAIT = !RESET && (miss_start || (state != IDLE));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        DATA_CACHE_READ_DATA = '0;
        if (!RESET && is_load && hit && state == IDLE) begin
            case (memReadEn[2:0])
                3'b000:  DATA_CACHE_READ_DATA = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  DATA_CACHE_READ_DATA = {{16{sel_half[15]}}, sel_half};
                3'b100:  DATA_CACHE_READ_DATA = {24'b0, sel_byte};
                3'b101:  DATA_CACHE_READ_DATA = {16'b0, sel_half};
                default: DATA_CACHE_READ_DATA = cur_word;
            endcase
        end
    end

    always_comb begin
        merged_word = cur_word;
        case (memWriteEn[1:0])
            2'b00:   merged_word[{DATA_CACHE_ADDR[1:0], 3'b0} +: 8] = DATA_CACHE_DATA[7:0];
            2'b01:   merged_word[{DATA_CACHE_ADDR[1], 4'b0} +: 16] = DATA_CACHE_DATA[15:0];
            default: merged_word = DATA_CACHE_DATA;
        endcase
        merged_line = cur_line;
        merged_line[{DATA_CACHE_ADDR[3:2], 5'b0} +: 32] = merged_word;
    end

    always_comb begin
        next_state    = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDR      = '0;
        MEM_WRITEDATA = '0;
        case (state)
            IDLE: begin
                if (miss_start)
                    next_state = dirty[index] ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDR      = {tag_array[miss_index], miss_index};
                MEM_WRITEDATA = data_array[miss_index];
                if (!MEM_BUSYWAIT)
                    next_state = FETCH;
            end
            FETCH: begin
                MEM_READ = 1'b1;
                MEM_ADDR = miss_blk;
                if (!MEM_BUSYWAIT)
                    next_state = UPDATE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state assigned with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            miss_blk <= '0;
        end else begin
            state <= next_state;
            if (miss_start)
                miss_blk <= DATA_CACHE_ADDR[31:4];
            if (state == UPDATE) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
            end else if (store_hit) begin
                dirty[index] <= 1'b1;
            end
        end
    end

    // NOTE: data, tag and refill storage carry no reset; cleared valid bits make them unreachable.
    always_ff @(posedge CLK) begin
        if (state == FETCH && !MEM_BUSYWAIT)
            refill_buf <= MEM_READDATA;
        if (state == UPDATE) begin
            data_array[miss_index] <= refill_buf;
            tag_array[miss_index]  <= miss_tag;
        end else if (store_hit) begin
            data_array[index] <= merged_line;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: an architectural byte-memory model predicts load results,
// stall lengths and memory block traffic; monitors compare whenever the DUT completes something.
`timescale 1ns/1ps
module tb_data_cache;
    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   memReadEn;
    logic [2:0]   memWriteEn;
    logic [31:0]  DATA_CACHE_ADDR, DATA_CACHE_DATA, DATA_CACHE_READ_DATA;
    logic         DATA_CACHE_BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .memReadEn(memReadEn), .memWriteEn(memWriteEn),
        .DATA_CACHE_ADDR(DATA_CACHE_ADDR), .DATA_CACHE_DATA(DATA_CACHE_DATA),
        .DATA_CACHE_READ_DATA(DATA_CACHE_READ_DATA), .DATA_CACHE_BUSY_WAIT(DATA_CACHE_BUSY_WAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- main memory responder ----------------
    logic [127:0] mem_store [32];
    logic [127:0] init_blk  [32];
    logic         mem_init;
    int           mem_lat;
    int           cnt;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < mem_lat);
    assign MEM_READDATA = mem_store[MEM_ADDR[4:0]];

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int b = 0; b < 32; b++) mem_store[b] <= init_blk[b];
            cnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            if (cnt < mem_lat) cnt <= cnt + 1;
            else begin
                cnt <= 0;
                if (MEM_WRITE) mem_store[MEM_ADDR[4:0]] <= MEM_WRITEDATA;
            end
        end else begin
            cnt <= 0;
        end
    end

    // ---------------- reference model & scoreboard ----------------
    typedef struct { logic [31:0] rdata; int stall; } exp_t;
    typedef struct { logic [27:0] addr; logic [127:0] data; } wb_t;
    exp_t        exp_q[$];
    wb_t         wb_q[$];
    logic [27:0] fetch_q[$];

    logic [7:0] arch [512];
    bit         m_valid [8];
    bit         m_dirty [8];
    int         m_tag   [8];

    function automatic logic [127:0] arch_block(input int blk);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = arch[blk*16 + i];
        return b;
    endfunction

    task automatic reload_arch();
        for (int b = 0; b < 32; b++)
            for (int i = 0; i < 16; i++) arch[b*16 + i] = mem_store[b][i*8 +: 8];
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    endtask

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input int a);
        int w = a & ~3;
        int h = a & ~1;
        logic [7:0]  bv = arch[a];
        logic [15:0] hv = {arch[h+1], arch[h]};
        case (f3)
            3'b000:  return {{24{bv[7]}}, bv};
            3'b001:  return {{16{hv[15]}}, hv};
            3'b100:  return {24'b0, bv};
            3'b101:  return {16'b0, hv};
            default: return {arch[w+3], arch[w+2], arch[w+1], arch[w]};
        endcase
    endfunction

    task automatic do_op(input bit st, input logic [2:0] code, input logic [31:0] addr,
                         input logic [31:0] data, input bit both);
        int   a   = int'(addr[8:0]);
        int   idx = int'(addr[6:4]);
        int   tg  = int'(addr[8:7]);
        exp_t e;
        bit   done = 0;
        e.stall = 0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            e.stall = mem_lat + 3;
            if (m_valid[idx] && m_dirty[idx]) begin
                e.stall += mem_lat + 1;
                wb_q.push_back('{addr: 28'(m_tag[idx]*8 + idx), data: arch_block(m_tag[idx]*8 + idx)});
            end
            fetch_q.push_back(addr[31:4]);
            m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
        end
        if (st) begin
            case (code[1:0])
                2'b00: arch[a] = data[7:0];
                2'b01: begin arch[a & ~1] = data[7:0]; arch[(a & ~1) + 1] = data[15:8]; end
                default: for (int i = 0; i < 4; i++) arch[(a & ~3) + i] = data[i*8 +: 8];
            endcase
            m_dirty[idx] = 1;
            e.rdata = '0;
        end else begin
            e.rdata = load_ref(code, a);
        end
        exp_q.push_back(e);

        @(posedge CLK); #1;
        memWriteEn      = st ? {1'b1, code[1:0]} : 3'b000;
        memReadEn       = st ? (both ? 4'b1010 : 4'b0000) : {1'b1, code};
        DATA_CACHE_ADDR = addr;
        DATA_CACHE_DATA = data;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (!DATA_CACHE_BUSY_WAIT) done = 1;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL op_timeout: addr %0h still stalled after 200 cycles", addr);
        end
        @(posedge CLK); #1;
        memReadEn  = '0;
        memWriteEn = '0;
    endtask

    // CPU-side monitor: a transaction completes on a cycle where access is held and BUSY_WAIT is low.
    initial begin
        int   stall_cnt = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESET) stall_cnt = 0;
            else if (memReadEn[3] || memWriteEn[2]) begin
                if (DATA_CACHE_BUSY_WAIT) stall_cnt++;
                else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_completion at addr %0h", DATA_CACHE_ADDR);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", DATA_CACHE_READ_DATA, e.rdata);
                    check("stall_cycles", stall_cnt, e.stall);
                    stall_cnt = 0;
                end
            end
        end
    end

    // Memory-side monitor: compares each completed block transfer.
    initial begin
        wb_t w;
        forever begin
            @(negedge CLK);
            if (!RESET && (MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
                check("read_write_exclusive", {MEM_READ, MEM_WRITE} == 2'b11, 1'b0);
                if (MEM_WRITE) begin
                    if (wb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_writeback addr %0h", MEM_ADDR);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_addr", MEM_ADDR, w.addr);
                        check("wb_data", MEM_WRITEDATA, w.data);
                    end
                end else if (fetch_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_fetch addr %0h", MEM_ADDR);
                end else begin
                    check("fetch_addr", MEM_ADDR, fetch_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        bit done;
        RESET = 1'b1; memReadEn = '0; memWriteEn = '0;
        DATA_CACHE_ADDR = '0; DATA_CACHE_DATA = '0;
        mem_lat = 2; mem_init = 1'b1;
        for (int b = 0; b < 32; b++) init_blk[b] = {$urandom, $urandom, $urandom, $urandom};
        init_blk[4][31:0] = 32'h1122_3344;
        repeat (3) @(posedge CLK);
        #1 mem_init = 1'b0;
        @(posedge CLK); #1 RESET = 1'b0;
        reload_arch();

        @(negedge CLK);
        check("reset_busy_wait", DATA_CACHE_BUSY_WAIT, 1'b0);
        check("reset_mem_read", MEM_READ, 1'b0);
        check("reset_mem_write", MEM_WRITE, 1'b0);
        check("reset_mem_addr", MEM_ADDR, 28'h0);
        check("reset_mem_writedata", MEM_WRITEDATA, 128'h0);
        check("reset_read_data", DATA_CACHE_READ_DATA, 32'h0);

        // clean miss, then hits with byte/half lane merging
        do_op(0, 3'b010, 32'h40, 0, 0);
        do_op(0, 3'b000, 32'h43, 0, 0);
        do_op(1, 3'b000, 32'h43, 32'h80, 0);
        do_op(0, 3'b000, 32'h43, 0, 0);
        do_op(0, 3'b100, 32'h43, 0, 0);
        do_op(1, 3'b001, 32'h42, 32'hBEEF, 0);
        do_op(0, 3'b010, 32'h40, 0, 0);
        do_op(0, 3'b001, 32'h42, 0, 0);
        // dirty conflict miss, then slow fetch
        mem_lat = 3;
        do_op(0, 3'b010, 32'h140, 0, 0);
        mem_lat = 5;
        do_op(0, 3'b010, 32'h1A0, 0, 0);

        // reset in the middle of a writeback discards the dirty line
        mem_lat = 4;
        do_op(1, 3'b010, 32'h144, 32'hCAFE_F00D, 0);
        @(posedge CLK); #1;
        memReadEn = 4'b1010; DATA_CACHE_ADDR = 32'h40;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (MEM_WRITE) done = 1;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL writeback_start_timeout: MEM_WRITE never rose");
        end
        @(posedge CLK); #1 RESET = 1'b1; memReadEn = '0;
        @(posedge CLK);
        @(negedge CLK);
        check("reset_mid_wb_mem_write", MEM_WRITE, 1'b0);
        check("reset_mid_wb_busy_wait", DATA_CACHE_BUSY_WAIT, 1'b0);
        @(posedge CLK); #1 RESET = 1'b0;
        reload_arch();
        mem_lat = 1;
        do_op(0, 3'b010, 32'h40, 0, 0);
        do_op(0, 3'b010, 32'h144, 0, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            bit st = ($urandom_range(0, 2) == 0);
            mem_lat = $urandom_range(0, 3);
            if (st) do_op(1, 3'($urandom_range(0, 2)), 32'($urandom_range(0, 511)), $urandom,
                          $urandom_range(0, 7) == 0);
            else    do_op(0, f3s[$urandom_range(0, 4)], 32'($urandom_range(0, 511)), 0, 0);
        end

        repeat (5) @(posedge CLK);
        check("exp_q_drained", exp_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("fetch_q_drained", fetch_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
